br_sb: RTL and testbench
========================

Name: br_sb

Overview:
- Parametrised successor to the MIPS register bank (BR).
- Clocked, depth- and width-configurable register file: two asynchronous read ports, one synchronous write port, and a per-register pending-write scoreboard.
- The scoreboard lets the decode stage stall on load-use hazards; register 0 is hardwired to zero.
- Sits between decode (RA1/RA2) and writeback (Di/Dir/Regw) in the datapath.

Parameters:
- DW, 32, data width of each register.
- AW, 5, address width; depth = 2**AW registers.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- RA1  input  AW  read address, port 1.
- RA2  input  AW  read address, port 2.
- DR1  output  DW  read data, port 1.
- DR2  output  DW  read data, port 2.
- Di  input  DW  write data.
- Dir  input  AW  write address.
- Regw  input  1  write enable.
- Sset  input  1  mark register SA as pending (load issued).
- SA  input  AW  scoreboard set address.
- Busy1  output  1  register RA1 has a pending write.
- Busy2  output  1  register RA2 has a pending write.
- Npend  output  AW+1  number of registers currently pending.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_n=0, async, no clock needed):
  - all registers = 0, all busy bits = 0, Npend = 0.
  - DR1/DR2 = 0, Busy1/Busy2 = 0 while reset is held.
  - Reset mid-operation discards any write or set in flight that cycle.
- Write: on rising clk, if Regw=1 and Dir!=0, then reg[Dir] <= Di. Writes to address 0 are ignored silently.
- Read: DR1 = reg[RA1] and DR2 = reg[RA2], combinational, zero latency. RA=0 always returns 0.
  - Without bypass, a same-cycle write becomes visible the cycle after the edge.
- Scoreboard busy bits b[i] update on rising clk:
  - set: Sset=1 and SA!=0 -> b[SA] <= 1.
  - clear: Regw=1 and Dir!=0 -> b[Dir] <= 0.
  - Same address set and cleared in one cycle: set wins (b=1). The data write still occurs.
  - Set on an already-busy register: stays 1, Npend unchanged.
  - Clear on a non-busy register: no effect, Npend unchanged.
  - b[0] is constantly 0; Sset with SA=0 is ignored.
- Busy1 = b[RA1], Busy2 = b[RA2], combinational.
- Npend is a registered counter equal to popcount(b). Per cycle it changes by +1, -1 or 0:
  - +1 for a set of a non-busy register.
  - -1 for a clear of a busy register at a different address.
  - 0 when both happen together, or when set and clear hit the same busy register.
  - Maximum value is 2**AW-1; it never wraps.
- No stall or handshake inside the block: the consumer stalls while Busy1 or Busy2 is high.

Optional Feature:
- Macro: BR_BYPASS_EN.
- Defined: write-first forwarding.
  - If Regw=1, Dir!=0 and Dir==RA1, then DR1 = Di combinationally and Busy1 = 0 in that cycle, unless Sset=1 with SA==Dir, in which case Busy1 stays as stored.
  - Same rule for port 2.
- Undefined: no forwarding; DR1/DR2 and Busy1/Busy2 reflect state before the edge only.

Test Plan:
- Reset/zero register: assert rst_n=0 mid-run with registers written -> DR1=DR2=0, Npend=0, Busy=0 immediately without a clock edge. Then Regw=1, Dir=0, Di=255 and read RA1=0 -> DR1=0.
- Basic write/read:
  - Write Di=255 to reg 1, Di=356 to reg 2, Di=646 to reg 3 on consecutive edges.
  - Then RA1=1, RA2=3 -> DR1=255, DR2=646.
  - Then Regw=0 with Di=149, Dir=1 -> reg 1 stays 255.
- Scoreboard set/clear:
  - Sset with SA=5, then SA=7 -> Npend=2; RA1=5 gives Busy1=1.
  - Write Dir=5, Di=10 -> Busy1=0, Npend=1, DR1=10.
- Simultaneous same-address: reg 9 busy, then Sset=1, SA=9 with Regw=1, Dir=9, Di=205 in one cycle -> reg9=205, Busy=1 for RA=9, Npend unchanged.
- Boundary: set all 31 nonzero registers -> Npend=31, no wrap. A repeated set of reg 4 keeps Npend=31. Clearing all -> Npend=0.
- Bypass, BR_BYPASS_EN defined: Regw=1, Dir=6, Di=856, RA1=6 in the same cycle -> DR1=856 before the edge. Macro undefined: DR1 = old value until after the edge.

Source files
------------

// File: rtl/br_sb.sv
// br_sb: parametrised register bank (2 async read ports, 1 sync write port, reg 0 = 0) with pending-write scoreboard; ports clk, rst_n, RA1/RA2 -> DR1/DR2 & Busy1/Busy2, Di/Dir/Regw write, Sset/SA scoreboard set, Npend pending count; define BR_BYPASS_EN for write-first forwarding
module br_sb #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] RA1,
  input  logic [AW-1:0] RA2,
  output logic [DW-1:0] DR1,
  output logic [DW-1:0] DR2,
  input  logic [DW-1:0] Di,
  input  logic [AW-1:0] Dir,
  input  logic          Regw,
  input  logic          Sset,
  input  logic [AW-1:0] SA,
  output logic          Busy1,
  output logic          Busy2,
  output logic [AW:0]   Npend
);
  localparam int N = 1 << AW;
  logic [DW-1:0] r [N];
  logic [N-1:0]  b;
  logic          we, set, inc, dec;
  assign we  = Regw && Dir != '0;
  assign set = Sset && SA != '0;
  assign inc = set && !b[SA];
  assign dec = we && b[Dir] && !(set && SA == Dir);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < N; i++) r[i] <= '0;
      b     <= '0;
      Npend <= '0;
    end else begin
      if (we) r[Dir] <= Di;
      if (we) b[Dir] <= 1'b0;
      if (set) b[SA] <= 1'b1;
      Npend <= Npend + (AW+1)'(inc) - (AW+1)'(dec);
    end
`ifdef BR_BYPASS_EN
  logic f1, f2, keep;
  assign keep  = set && SA == Dir;
  assign f1    = rst_n && we && Dir == RA1;
  assign f2    = rst_n && we && Dir == RA2;
  assign DR1   = f1 ? Di : r[RA1];
  assign DR2   = f2 ? Di : r[RA2];
  assign Busy1 = f1 && !keep ? 1'b0 : b[RA1];
  assign Busy2 = f2 && !keep ? 1'b0 : b[RA2];
`else
  assign DR1   = r[RA1];
  assign DR2   = r[RA2];
  assign Busy1 = b[RA1];
  assign Busy2 = b[RA2];
`endif
endmodule

// File: tb/tb_br_sb.sv
// tb_br_sb: directed, model-checked bench for br_sb
module tb_br_sb;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int N = 1 << AW;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [AW-1:0] RA1 = '0, RA2 = '0, Dir = '0, SA = '0;
  logic [DW-1:0] Di = '0, DR1, DR2;
  logic Regw = 1'b0, Sset = 1'b0, Busy1, Busy2;
  logic [AW:0] Npend;
  int n_chk = 0, n_fail = 0;
  logic [DW-1:0] m_reg [N];
  logic m_b [N];
  br_sb #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .RA1(RA1), .RA2(RA2), .DR1(DR1), .DR2(DR2),
    .Di(Di), .Dir(Dir), .Regw(Regw), .Sset(Sset), .SA(SA),
    .Busy1(Busy1), .Busy2(Busy2), .Npend(Npend)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_reg[i] <= '0;
        m_b[i] <= 1'b0;
      end
    end else begin
      if (Regw && Dir != 0) begin
        m_reg[Dir] <= Di;
        m_b[Dir] <= 1'b0;
      end
      if (Sset && SA != 0) m_b[SA] <= 1'b1;
    end
  function automatic logic [DW-1:0] exp_dr(input logic [AW-1:0] ra);
`ifdef BR_BYPASS_EN
    if (rst_n && Regw && Dir != 0 && Dir == ra) return Di;
`endif
    return m_reg[ra];
  endfunction
  function automatic logic exp_busy(input logic [AW-1:0] ra);
`ifdef BR_BYPASS_EN
    if (rst_n && Regw && Dir != 0 && Dir == ra && !(Sset && SA == Dir)) return 1'b0;
`endif
    return m_b[ra];
  endfunction
  always @(negedge clk) begin
    int cnt;
    cnt = 0;
    for (int i = 0; i < N; i++) cnt += int'(m_b[i]);
    chk("model_dr1", DR1, exp_dr(RA1));
    chk("model_dr2", DR2, exp_dr(RA2));
    chk("model_busy1", Busy1, exp_busy(RA1));
    chk("model_busy2", Busy2, exp_busy(RA2));
    chk("model_npend", Npend, cnt);
  end
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic idle();
    Regw = 1'b0;
    Sset = 1'b0;
  endtask
  initial begin
    #12 rst_n = 1'b1;
    #1;
    chk("reset_dr1", DR1, 0);
    chk("reset_npend", Npend, 0);
    step();
    Regw = 1; Dir = 1; Di = 255; step();
    Dir = 2; Di = 356; step();
    Dir = 3; Di = 646; step();
    idle(); RA1 = 1; RA2 = 3; #1;
    chk("rd_reg1", DR1, 255);
    chk("rd_reg3", DR2, 646);
    Di = 149; Dir = 1; step(); #1;
    chk("no_write_reg1", DR1, 255);
    Sset = 1; SA = 5; step();
    SA = 7; step();
    idle(); RA1 = 5; #1;
    chk("sb_npend2", Npend, 2);
    chk("sb_busy5", Busy1, 1);
    Regw = 1; Dir = 5; Di = 10; step();
    idle(); #1;
    chk("sb_clr_busy", Busy1, 0);
    chk("sb_clr_npend", Npend, 1);
    chk("sb_clr_data", DR1, 10);
    Sset = 1; SA = 9; step();
    Regw = 1; Dir = 9; Di = 205; step();
    idle(); RA1 = 9; #1;
    chk("same_data", DR1, 205);
    chk("same_busy", Busy1, 1);
    chk("same_npend", Npend, 2);
    for (int i = 1; i < N; i++) begin
      Sset = 1; SA = AW'(i); step();
    end
    idle(); #1;
    chk("all_npend", Npend, 31);
    Sset = 1; SA = 4; step();
    idle(); #1;
    chk("reset4_npend", Npend, 31);
    Sset = 1; SA = 0; step();
    idle(); RA1 = 0; #1;
    chk("sa0_npend", Npend, 31);
    chk("sa0_busy", Busy1, 0);
    for (int i = 1; i < N; i++) begin
      Regw = 1; Dir = AW'(i); Di = DW'(i * 3); step();
    end
    idle(); #1;
    chk("clr_all_npend", Npend, 0);
    Regw = 1; Dir = 4; Di = 77; step();
    idle(); #1;
    chk("clr_idle_npend", Npend, 0);
    Regw = 1; Dir = 6; Di = 856; RA1 = 6; #1;
`ifdef BR_BYPASS_EN
    chk("bypass_pre", DR1, 856);
`else
    chk("bypass_pre", DR1, 18);
`endif
    step();
    idle(); #1;
    chk("bypass_post", DR1, 856);
    Sset = 1; SA = 3; step();
    idle(); RA1 = 1; RA2 = 3; #1;
    chk("pre_rst_npend", Npend, 1);
    Regw = 1; Dir = 2; Di = 999; Sset = 1; SA = 8;
    rst_n = 1'b0; #1;
    chk("rst_dr1", DR1, 0);
    chk("rst_dr2", DR2, 0);
    chk("rst_busy2", Busy2, 0);
    chk("rst_npend", Npend, 0);
    step();
    rst_n = 1'b1; idle(); RA2 = 2; #1;
    chk("rst_discard", DR2, 0);
    Regw = 1; Dir = 0; Di = 255; RA1 = 0; step();
    idle(); #1;
    chk("zero_reg", DR1, 0);
    chk("zero_npend", Npend, 0);
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
